// File: rtl/sa_step_responder_int.sv
// Integer responder for the systolic-array step protocol: one rank-1 update C += a*b^T per step, one row per cycle.
// Optional macro SA_RESP_SAT_EN: saturating products/sums plus a sticky sat_flag output.
module sa_step_responder_int #(
    parameter int M = 8,
    parameter int N = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              step_valid,
    input  logic [M*32-1:0]   a_row_flat,
    input  logic [N*32-1:0]   b_col_flat,
    input  logic              k_first,
    input  logic              k_last,
    output logic              step_ready,
    output logic [M*N*32-1:0] c_out_flat,
    output logic [M*N-1:0]    c_valid_flat,
    output logic              proto_err
`ifdef SA_RESP_SAT_EN
    ,
    output logic              sat_flag
`endif
);

    localparam int R_W = (M > 1) ? $clog2(M) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, PUBLISH} state_t;

    state_t           state_q, state_d;
    logic [R_W-1:0]   r_q, r_d;
    logic             ready_q, ready_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic             open_q, open_d;
    logic             kf_q, kf_d;
    logic             kl_q, kl_d;
    logic [31:0]      a_q [M];
    logic [31:0]      a_d [M];
    logic [31:0]      b_q [N];
    logic [31:0]      b_d [N];
    logic [31:0]      acc_q [M][N];
    logic [31:0]      acc_d [M][N];
    logic [31:0]      base;

`ifdef SA_RESP_SAT_EN
    logic             sat_q, sat_d;
    logic [32:0]      prod_s, sum_s;

    // Returns {saturated, value}: full 64-bit product clamped to the int32 range.
    function automatic logic [32:0] mul_sat(input logic [31:0] x, input logic [31:0] y);
        logic signed [63:0] p;
        p = $signed(x) * $signed(y);
        if (p > 64'sd2147483647)
            return {1'b1, 32'h7FFF_FFFF};
        else if (p < -64'sd2147483648)
            return {1'b1, 32'h8000_0000};
        else
            return {1'b0, p[31:0]};
    endfunction

    function automatic logic [32:0] add_sat(input logic [31:0] x, input logic [31:0] y);
        logic signed [32:0] s;
        s = $signed({x[31], x}) + $signed({y[31], y});
        if (s[32] != s[31])
            return {1'b1, s[32] ? 32'h8000_0000 : 32'h7FFF_FFFF};
        else
            return {1'b0, s[31:0]};
    endfunction
`endif

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        ready_d = ready_q;
        valid_d = valid_q;
        err_d   = err_q;
        open_d  = open_q;
        kf_d    = kf_q;
        kl_d    = kl_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        base    = '0;
`ifdef SA_RESP_SAT_EN
        sat_d   = sat_q;
        prod_s  = '0;
        sum_s   = '0;
`endif
        case (state_q)
            IDLE: begin
                if (step_valid && ready_q) begin
                    for (int i = 0; i < M; i++) a_d[i] = a_row_flat[i*32 +: 32];
                    for (int j = 0; j < N; j++) b_d[j] = b_col_flat[j*32 +: 32];
                    kf_d    = k_first;
                    kl_d    = k_last;
                    ready_d = 1'b0;
                    r_d     = '0;
                    state_d = BUSY;
                    if (k_first) begin
                        valid_d = 1'b0;
                        open_d  = 1'b1;
`ifdef SA_RESP_SAT_EN
                        sat_d   = 1'b0;
`endif
                    end else if (!open_q) begin
                        // Accumulate without an open tile is flagged but still executed.
                        err_d = 1'b1;
                    end
                end
            end
            BUSY: begin
                for (int j = 0; j < N; j++) begin
                    base = kf_q ? 32'h0 : acc_q[r_q][j];
`ifdef SA_RESP_SAT_EN
                    prod_s = mul_sat(a_q[r_q], b_q[j]);
                    sum_s  = add_sat(base, prod_s[31:0]);
                    acc_d[r_q][j] = sum_s[31:0];
                    sat_d  = sat_d | prod_s[32] | sum_s[32];
`else
                    acc_d[r_q][j] = base + a_q[r_q] * b_q[j];
`endif
                end
                if (r_q == R_W'(M - 1)) begin
                    if (kl_q) begin
                        state_d = PUBLISH;
                    end else begin
                        state_d = IDLE;
                        ready_d = 1'b1;
                    end
                end else begin
                    r_d = r_q + 1'b1;
                end
            end
            PUBLISH: begin
                valid_d = 1'b1;
                ready_d = 1'b1;
                open_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; blocking here would race with readers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            r_q     <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            open_q  <= 1'b0;
            kf_q    <= 1'b0;
            kl_q    <= 1'b0;
            // NOTE: the accumulator array is reset explicitly because c_out_flat exposes it directly.
            for (int i = 0; i < M; i++) begin
                a_q[i] <= '0;
                for (int j = 0; j < N; j++) acc_q[i][j] <= '0;
            end
            for (int j = 0; j < N; j++) b_q[j] <= '0;
`ifdef SA_RESP_SAT_EN
            sat_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            open_q  <= open_d;
            kf_q    <= kf_d;
            kl_q    <= kl_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
`ifdef SA_RESP_SAT_EN
            sat_q   <= sat_d;
`endif
        end
    end

    for (genvar gi = 0; gi < M; gi++) begin : g_row
        for (genvar gj = 0; gj < N; gj++) begin : g_col
            assign c_out_flat[(gi*N+gj)*32 +: 32] = acc_q[gi][gj];
        end
    end

    assign step_ready   = ready_q;
    assign c_valid_flat = {(M*N){valid_q}};
    assign proto_err    = err_q;
`ifdef SA_RESP_SAT_EN
    assign sat_flag     = sat_q;
`endif

endmodule
